// File: rtl/angle_read_scheduler_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : angle_read_scheduler_pkg                                      |
// | Purpose  : Shared types and constants for the AS5600 angle read          |
// |            scheduler and the swerve rotation controller: scheduler FSM   |
// |            state encoding, raw angle width, small helpers.               |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package angle_read_scheduler_pkg;

  // Raw AS5600 angle width; also consumed by the rotation controller.
  localparam int c_ANGLE_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SETTLE  = 3'd4
  } sched_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/angle_read_scheduler_rr_arbiter.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : angle_read_scheduler_rr_arbiter                               |
// | Purpose  : Combinational round-robin pick: first requesting channel at   |
// |            or after ptr, scanning cyclically.                            |
// | Ports    : req   in  NUM_CH  request lines                               |
// |            ptr   in  CH_W    scan start channel                          |
// |            grant out CH_W    selected channel (ptr when none request)    |
// |            any   out 1       at least one request present                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module angle_read_scheduler_rr_arbiter
  import angle_read_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              any
);

  logic [CH_W-1:0] w_idx;
  logic            w_found;

  // Walk the channels starting at ptr; the index wraps at NUM_CH-1 so that
  // non-power-of-two channel counts scan correctly too.
  always_comb begin
    grant   = ptr;
    w_found = 1'b0;
    w_idx   = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && req[w_idx]) begin
        grant   = w_idx;
        w_found = 1'b1;
      end
      if (w_idx == CH_W'(NUM_CH - 1)) w_idx = '0;
      else                            w_idx = w_idx + CH_W'(1);
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/angle_read_scheduler.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : angle_read_scheduler                                          |
// | Purpose  : Time-shares one AS5600 I2C read engine across NUM_CH          |
// |            encoders. Round-robin grant, mux select setup, engine run via |
// |            active-low hold, rd_done edge capture, timeout, settle.       |
// | Ports    : clock          in  1          main clock                      |
// |            reset_n        in  1          async active-low reset          |
// |            enable         in  1          scheduler enable (IDLE only)    |
// |            req            in  NUM_CH     per-channel request (level)     |
// |            eng_hold       out 1          1 = engine idle, 0 = run        |
// |            eng_rd_done    in  1          engine read done (multi-clock)  |
// |            eng_raw_angle  in  12         engine raw angle                |
// |            chan_sel       out CH_W       I2C mux select                  |
// |            angle          out NUM_CH*12  captured angles, ch i at 12i     |
// |            angle_valid    out NUM_CH     good capture since reset        |
// |            angle_upd      out NUM_CH     one-clock capture pulse         |
// |            err            out NUM_CH     sticky timeout flag             |
// |            busy           out 1          not IDLE                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module angle_read_scheduler
  import angle_read_scheduler_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int MUX_SETUP      = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           req,
  output logic                        eng_hold,
  input  logic                        eng_rd_done,
  input  logic [c_ANGLE_W-1:0]        eng_raw_angle,
  output logic [CH_W-1:0]             chan_sel,
  output logic [NUM_CH*c_ANGLE_W-1:0] angle,
  output logic [NUM_CH-1:0]           angle_valid,
  output logic [NUM_CH-1:0]           angle_upd,
  output logic [NUM_CH-1:0]           err,
  output logic                        busy
);

  localparam int c_CNT_MAX = max3(MUX_SETUP, SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  sched_state_t         r_state;
  sched_state_t         w_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_rd_q;
  logic [CH_W-1:0]      r_ptr;
  logic [CH_W-1:0]      r_chan_sel;
  logic [CH_W-1:0]      w_grant;
  logic                 w_any;
  logic                 w_rd_edge;
  logic                 w_start;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_cnt_clr;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
  endfunction

  angle_read_scheduler_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  // Only the first high clock of eng_rd_done counts as a read completion.
  assign w_rd_edge = eng_rd_done & ~r_rd_q;

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    eng_hold  = 1'b1;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (enable && w_any) begin
          w_start = 1'b1;
          w_next  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (r_cnt == c_CNT_W'(MUX_SETUP - 1)) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_RUN;
        end
      end
      ST_RUN: begin
        eng_hold = 1'b0;
        // A completion in the same clock as the timeout limit is a success.
        if (w_rd_edge) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_CAPTURE;
        end else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == c_CNT_W'(SETTLE_CYCLES - 1)) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: begin
        w_cnt_clr = 1'b1;
        w_next    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rd_q     <= 1'b0;
      r_ptr      <= '0;
      r_chan_sel <= '0;
    end else begin
      r_state <= w_next;
      r_rd_q  <= eng_rd_done;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + c_CNT_W'(1);
      // The mux only moves while the engine is held idle.
      if (w_start) r_chan_sel <= w_grant;
      if (w_capture || w_timeout) r_ptr <= next_ch(r_chan_sel);
    end
  end

  assign chan_sel = r_chan_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                 w_hit;
    logic [c_ANGLE_W-1:0] r_angle;
    logic                 r_valid;
    logic                 r_upd;
    logic                 r_err;

    assign w_hit = (r_chan_sel == CH_W'(i));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_angle <= '0;
        r_valid <= 1'b0;
        r_upd   <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        r_upd <= w_capture && w_hit;
        if (w_capture && w_hit) begin
          r_angle <= eng_raw_angle;
          r_valid <= 1'b1;
          r_err   <= 1'b0;
        end else if (w_timeout && w_hit) begin
          r_err <= 1'b1;
        end
      end
    end

    assign angle[i*c_ANGLE_W +: c_ANGLE_W] = r_angle;
    assign angle_valid[i]                  = r_valid;
    assign angle_upd[i]                    = r_upd;
    assign err[i]                          = r_err;
  end

endmodule

`default_nettype wire

// File: tb/tb_angle_read_scheduler.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_angle_read_scheduler                                       |
// | Purpose  : Self-checking bench for angle_read_scheduler with a behaviour |
// |            model of grant order, capture registers and flags.           |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_angle_read_scheduler;

  localparam int NUM_CH         = 4;
  localparam int MUX_SETUP      = 8;
  localparam int SETTLE_CYCLES  = 16;
  localparam int TIMEOUT_CYCLES = 1024;

  logic        clock         = 1'b0;
  logic        reset_n       = 1'b0;
  logic        enable        = 1'b0;
  logic [3:0]  req           = 4'b0000;
  logic        eng_rd_done   = 1'b0;
  logic [11:0] eng_raw_angle = 12'h000;
  logic        eng_hold;
  logic [1:0]  chan_sel;
  logic [47:0] angle;
  logic [3:0]  angle_valid;
  logic [3:0]  angle_upd;
  logic [3:0]  err;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: what the outside world should see.
  logic [11:0] m_angle [4];
  logic [3:0]  m_valid;
  logic [3:0]  m_err;
  int          m_ptr;

  angle_read_scheduler #(
    .NUM_CH         (NUM_CH),
    .CH_W           (2),
    .MUX_SETUP      (MUX_SETUP),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .req           (req),
    .eng_hold      (eng_hold),
    .eng_rd_done   (eng_rd_done),
    .eng_raw_angle (eng_raw_angle),
    .chan_sel      (chan_sel),
    .angle         (angle),
    .angle_valid   (angle_valid),
    .angle_upd     (angle_upd),
    .err           (err),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_angle[i] = 12'h000;
    m_valid = 4'b0000;
    m_err   = 4'b0000;
    m_ptr   = 0;
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      c = (m_ptr + i) % NUM_CH;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [47:0] exp_angle_vec();
    logic [47:0] v;
    for (int i = 0; i < 4; i++) v[i*12 +: 12] = m_angle[i];
    return v;
  endfunction

  // One complete transaction: request, engine start, optional response,
  // settle, then the visible state against the model.
  task automatic run_read(input logic [3:0] r, input bit respond, input logic [11:0] raw,
                          input int dly, input bit drop, input bit spur);
    int g, n, k, busy_k;
    bit started, done, upd_bad, hold_bad, sel_bad;
    logic [1:0] g2, sel_first;
    logic [3:0] exp_upd;
    g   = pick(r);
    g2  = 2'(g);
    req = r;
    enable = 1'b1;
    n = 0; started = 0; sel_first = 2'b00;
    while (!started && n < 100) begin
      @(negedge clock);
      n++;
      if (n == 1) sel_first = chan_sel;
      if (eng_hold === 1'b0) started = 1;
    end
    total_cnt++;
    if (!started || n != 1 + MUX_SETUP)
      $display("FAIL start_latency: got %0d clocks (started=%0d) required %0d", n, started, 1 + MUX_SETUP);
    else pass_cnt++;
    total_cnt++;
    if (sel_first !== g2) $display("FAIL grant: chan_sel got %0d required %0d", sel_first, g2);
    else pass_cnt++;
    if (!started) begin
      req = 4'b0000;
      return;
    end
    sel_bad = 0;
    if (drop) begin
      req    = 4'b0000;
      enable = 1'b0;
    end
    if (respond) begin
      repeat (dly) begin
        @(negedge clock);
        if (eng_hold !== 1'b0 || chan_sel !== g2) sel_bad = 1;
      end
      eng_raw_angle = raw;
      eng_rd_done   = 1'b1;
      k = 0; busy_k = -1; upd_bad = 0; hold_bad = 0;
      while (busy_k < 0 && k < 60) begin
        @(negedge clock);
        k++;
        if (k == 4) begin
          eng_rd_done   = 1'b0;
          eng_raw_angle = 12'($urandom);
        end
        if (spur && k == 8)  eng_rd_done = 1'b1;
        if (spur && k == 10) eng_rd_done = 1'b0;
        exp_upd = (k == 2) ? (4'b0001 << g) : 4'b0000;
        if (angle_upd !== exp_upd) upd_bad = 1;
        if (eng_hold !== 1'b1) hold_bad = 1;
        if (busy === 1'b0) busy_k = k;
      end
      total_cnt++;
      if (upd_bad) $display("FAIL upd_pulse: angle_upd pattern wrong for ch %0d, required single pulse 2 clocks after rd_done", g);
      else pass_cnt++;
      total_cnt++;
      if (hold_bad) $display("FAIL hold_after_done: eng_hold got 0 required 1 after rd_done edge");
      else pass_cnt++;
      total_cnt++;
      if (busy_k != 2 + SETTLE_CYCLES) $display("FAIL settle_len: busy low after %0d clocks required %0d", busy_k, 2 + SETTLE_CYCLES);
      else pass_cnt++;
      m_angle[g] = raw;
      m_valid[g] = 1'b1;
      m_err[g]   = 1'b0;
    end else begin
      n = 1; done = 0;
      while (!done && n < 2000) begin
        @(negedge clock);
        if (eng_hold === 1'b1) done = 1;
        else begin
          n++;
          if (chan_sel !== g2) sel_bad = 1;
        end
      end
      total_cnt++;
      if (n != TIMEOUT_CYCLES) $display("FAIL timeout_len: run lasted %0d clocks required %0d", n, TIMEOUT_CYCLES);
      else pass_cnt++;
      m_err[g] = 1'b1;
      k = 0;
      while (busy === 1'b1 && k < 60) begin
        @(negedge clock);
        k++;
      end
      total_cnt++;
      if (k != SETTLE_CYCLES) $display("FAIL timeout_settle: busy low after %0d clocks required %0d", k, SETTLE_CYCLES);
      else pass_cnt++;
    end
    m_ptr = (g + 1) % NUM_CH;
    total_cnt++;
    if (sel_bad) $display("FAIL sel_stable: chan_sel moved during run, required %0d", g2);
    else pass_cnt++;
    total_cnt++;
    if (angle !== exp_angle_vec()) $display("FAIL angle: got %h required %h", angle, exp_angle_vec());
    else pass_cnt++;
    total_cnt++;
    if (angle_valid !== m_valid) $display("FAIL valid: got %b required %b", angle_valid, m_valid);
    else pass_cnt++;
    total_cnt++;
    if (err !== m_err) $display("FAIL err: got %b required %b", err, m_err);
    else pass_cnt++;
    total_cnt++;
    if (eng_hold !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after: eng_hold=%b busy=%b required 1/0", eng_hold, busy);
    else pass_cnt++;
    req = 4'b0000;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total_cnt++;
    if (eng_hold !== 1'b1) $display("FAIL reset_hold: got %b required 1", eng_hold); else pass_cnt++;
    total_cnt++;
    if (chan_sel !== 2'd0) $display("FAIL reset_sel: got %0d required 0", chan_sel); else pass_cnt++;
    total_cnt++;
    if (angle !== 48'h0) $display("FAIL reset_angle: got %h required 0", angle); else pass_cnt++;
    total_cnt++;
    if ({angle_valid, angle_upd, err} !== 12'h000)
      $display("FAIL reset_flags: got %b/%b/%b required zeros", angle_valid, angle_upd, err);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 5; i++) run_read(4'b1111, 1'b1, 12'(12'h100 + (i % 4)), i, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    run_read(4'b0100, 1'b1, 12'hABC, 2, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_read(4'b0010, 1'b0, 12'h000, 0, 1'b0, 1'b0);
    run_read(4'b0010, 1'b1, 12'h5A5, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int n;
    req = 4'b0100;
    enable = 1'b1;
    n = 0;
    while (eng_hold !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    total_cnt++;
    if (eng_hold !== 1'b0) $display("FAIL midrun_start: eng_hold got %b required 0", eng_hold); else pass_cnt++;
    repeat (3) @(negedge clock);
    req = 4'b0000;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (eng_hold !== 1'b1 || busy !== 1'b0 || chan_sel !== 2'd0)
      $display("FAIL async_reset_ctl: hold=%b busy=%b sel=%0d required 1/0/0", eng_hold, busy, chan_sel);
    else pass_cnt++;
    total_cnt++;
    if (angle !== 48'h0 || {angle_valid, angle_upd, err} !== 12'h000)
      $display("FAIL async_reset_data: angle=%h flags=%b/%b/%b required zeros", angle, angle_valid, angle_upd, err);
    else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    // Scan restarts from channel 0, so channel 1 wins over channel 3.
    run_read(4'b1010, 1'b1, 12'h3C7, 0, 1'b0, 1'b0);
  endtask

  task automatic test_enable_drop();
    bit bad;
    run_read(4'b0001, 1'b1, 12'h777, 3, 1'b1, 1'b0);
    bad = 0;
    req = 4'b1111;
    repeat (20) begin
      @(negedge clock);
      if (busy !== 1'b0 || eng_hold !== 1'b1) bad = 1;
    end
    total_cnt++;
    if (bad) $display("FAIL enable_idle: scheduler left IDLE while disabled, required stay idle");
    else pass_cnt++;
    req = 4'b0000;
    enable = 1'b1;
  endtask

  task automatic test_spurious();
    bit bad;
    bad = 0;
    eng_raw_angle = 12'hFFF;
    @(negedge clock);
    eng_rd_done = 1'b1;
    repeat (3) @(negedge clock);
    eng_rd_done = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (angle_upd !== 4'b0000 || busy !== 1'b0) bad = 1;
    end
    total_cnt++;
    if (bad) $display("FAIL spurious_idle: capture or start on idle rd_done, required none");
    else pass_cnt++;
    total_cnt++;
    if (angle !== exp_angle_vec()) $display("FAIL spurious_angle: got %h required %h", angle, exp_angle_vec());
    else pass_cnt++;
    run_read(4'b1000, 1'b1, 12'h2D4, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if (r == 4'b0000) begin
        req = r;
        repeat (5) @(negedge clock);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rand_noreq: busy got %b required 0", busy);
        else pass_cnt++;
      end else begin
        run_read(r, ($urandom_range(0, 9) != 0), 12'($urandom), $urandom_range(0, 6), 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_reset_mid_run();
    test_enable_drop();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
